sha2_t2_pipe: RTL and testbench
===============================

Name: sha2_t2_pipe

Overview:
- Parametrised, pipelined successor to the combinational SHA-256 T2 term (Sigma0(a) + Maj(a,b,c)).
- Supports 32-bit words (SHA-224/256) and 64-bit words (SHA-384/512) through a single parameter.
- Adds valid/ready elastic handshakes on both sides, two registered stages, and full backpressure.
- Sits between the working-variable register file and the round-update adder in the compression core.

Parameters:
- WORD, 32, word width; legal values 32 or 64 only; any other value fails elaboration via an assertion.
- SKID, 0, when 1 adds a 1-entry skid buffer on the output so out_ready has no combinational path to in_ready.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  a/b/c are valid this cycle
- in_ready  output  1  block accepts the input this cycle
- a  input  WORD  working variable a
- b  input  WORD  working variable b
- c  input  WORD  working variable c
- out_valid  output  1  t2 is valid
- out_ready  input  1  downstream accepts t2
- t2  output  WORD  Sigma0(a) + Maj(a,b,c) mod 2^WORD

Behaviour:
- Transfer occurs on a rising clk edge when valid and ready are both high on the same interface.
- Stage 1 registers sigma0 and maj:
  - WORD=32: sigma0 = ROTR2 ^ ROTR13 ^ ROTR22.
  - WORD=64: sigma0 = ROTR28 ^ ROTR34 ^ ROTR39.
  - maj = (a&b)^(a&c)^(b&c).
- Stage 2 registers t2 = s1_sigma0 + s1_maj, truncated to WORD bits; carry out is discarded.
- Latency: accepted input appears on t2/out_valid exactly 2 cycles later when unstalled. Throughput is 1 per cycle with no bubbles.
- Stall rules:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = s1 advances. With SKID=0 this is combinational from out_ready.
- SKID=1:
  - Skid entry captures the stage-2 result when out_ready is low while s2 holds data.
  - in_ready is a registered signal.
  - Latency remains 2 when unstalled.
- Data registers hold their value while stalled. t2 must stay stable while out_valid=1 && out_ready=0.
- Reset:
  - All valid flags clear to 0: out_valid=0, in_ready=1 on the first cycle after reset.
  - t2 resets to 0, and the data registers clear.
  - Reset mid-operation discards in-flight words; no partial output is produced.
- Simultaneous in-transfer and out-transfer with a full pipe is legal and keeps the pipe full.
- in_valid with in_ready=0: the input is not consumed, and the source must hold it (AXI-style rules).

Optional Feature:
- Macro: SHA2_T2_NEW_A_EN.
- When defined:
  - Adds input t1 [WORD] (sampled with a/b/c) and output new_a [WORD].
  - t1 is carried through stage 1, and stage 2 computes new_a = t1 + sigma0 + maj mod 2^WORD.
  - new_a has the same valid, latency and reset value 0 as t2.
- When undefined: the ports and logic are absent, and the behaviour is otherwise identical.

Decomposition:
- Package sha2_pkg holds:
  - ROT constants for each WORD: ROT32_S0 = {2,13,22} and ROT64_S0 = {28,34,39}.
  - Functions rotr(), big_sigma0(), maj(), parametrised by width.
- Sub-module sha2_pipe_stage: a single generic valid/ready register slice. It is instantiated twice, plus once more as the skid when SKID=1.

Test Plan:
- WORD=32, a=6a09e667 b=bb67ae85 c=3c6ef372, out_ready=1 -> t2=08909ae5 (sigma0=ce20b47e, maj=3a6fe667) with out_valid 2 cycles after accept.
- WORD=32 and WORD=64, a=b=c=all-ones -> t2=FFFFFFFE / FFFFFFFFFFFFFFFE (wrap), a=b=c=0 -> t2=0.
- Back-to-back 8 random vectors with out_ready=1 -> 8 consecutive out_valid cycles; results match the reference model in order.
- Random out_ready throttling (30% low) with continuous in_valid -> no loss or duplication, t2 stable while stalled; with SKID=1, in_ready never combinationally follows out_ready.
- Assert rst while 2 words are in flight -> next cycle out_valid=0, t2=0, in_ready=1; the following vector is processed normally.
- SHA2_T2_NEW_A_EN, WORD=32, t1=54da50e8 with the first vector above -> new_a=5d6aebcd, t2=08909ae5.

Source files
------------

// File: rtl/sha2_pkg.sv
// sha2_pkg: SHA-2 rotation constants and round-function helpers for 32/64-bit words
package sha2_pkg;
  localparam int ROT32_S0 [3] = '{2, 13, 22};
  localparam int ROT64_S0 [3] = '{28, 34, 39};
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] m, v;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v = x & m;
    return ((v >> n) | (v << (w - n))) & m;
  endfunction
  function automatic logic [63:0] big_sigma0(input logic [63:0] x, input int w);
    return (w == 64) ?
      (rotr(x, ROT64_S0[0], w) ^ rotr(x, ROT64_S0[1], w) ^ rotr(x, ROT64_S0[2], w)) :
      (rotr(x, ROT32_S0[0], w) ^ rotr(x, ROT32_S0[1], w) ^ rotr(x, ROT32_S0[2], w));
  endfunction
  function automatic logic [63:0] maj(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
endpackage

// File: rtl/sha2_pipe_stage.sv
// sha2_pipe_stage: valid/ready register slice; BYPASS=1 turns it into a zero-latency skid entry
module sha2_pipe_stage #(
  parameter int W      = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q, valid_d, load;
  logic [W-1:0] data_q, data_d;
  // a slice refills whenever it is empty or draining; a skid only captures a word the sink refused
  always_comb begin
    load    = BYPASS ? (in_valid && !valid_q && !out_ready) : (in_valid && (!valid_q || out_ready));
    valid_d = BYPASS ? (valid_q ? !out_ready : load) : ((!valid_q || out_ready) ? in_valid : valid_q);
    data_d  = load ? in_data : data_q;
  end
  // state registers, cleared synchronously
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign in_ready  = BYPASS ? !valid_q : (!valid_q || out_ready);
  assign out_valid = valid_q || (BYPASS && in_valid);
  assign out_data  = (BYPASS && !valid_q) ? in_data : data_q;
endmodule

// File: rtl/sha2_t2_pipe.sv
// sha2_t2_pipe: two-stage elastic SHA-2 T2 = Sigma0(a) + Maj(a,b,c); optional new_a under SHA2_T2_NEW_A_EN
module sha2_t2_pipe
  import sha2_pkg::*;
#(
  parameter int WORD = 32,
  parameter int SKID = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  input  logic [WORD-1:0] c,
`ifdef SHA2_T2_NEW_A_EN
  input  logic [WORD-1:0] t1,
  output logic [WORD-1:0] new_a,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] t2
);
`ifdef SHA2_T2_NEW_A_EN
  localparam int P1 = 3 * WORD;
  localparam int P2 = 2 * WORD;
`else
  localparam int P1 = 2 * WORD;
  localparam int P2 = WORD;
`endif
  if (!(WORD == 32 || WORD == 64)) begin : g_bad_word
    $error("sha2_t2_pipe: WORD must be 32 or 64");
  end
  logic [WORD-1:0] sig, mj, s1_sig, s1_mj, sum;
  logic [P1-1:0]   s1_in, s1_out;
  logic [P2-1:0]   s2_in, s2_out, res;
  logic            s1_v, s1_rdy, s2_v, s2_rdy;
  // round-function terms from the raw working variables, packed for stage 1
  always_comb begin
    sig   = WORD'(big_sigma0(64'(a), WORD));
    mj    = WORD'(maj(64'(a), 64'(b), 64'(c)));
`ifdef SHA2_T2_NEW_A_EN
    s1_in = {t1, sig, mj};
`else
    s1_in = {sig, mj};
`endif
  end
  sha2_pipe_stage #(.W(P1), .BYPASS(1'b0)) u_s1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(s1_in),
    .out_valid(s1_v), .out_ready(s1_rdy), .out_data(s1_out)
  );
  // final modular adds feeding stage 2; carry out is dropped by the WORD-wide sum
  always_comb begin
    s1_sig = s1_out[2*WORD-1:WORD];
    s1_mj  = s1_out[WORD-1:0];
    sum    = s1_sig + s1_mj;
`ifdef SHA2_T2_NEW_A_EN
    s2_in  = {s1_out[3*WORD-1:2*WORD] + sum, sum};
`else
    s2_in  = sum;
`endif
  end
  sha2_pipe_stage #(.W(P2), .BYPASS(1'b0)) u_s2 (
    .clk(clk), .rst(rst),
    .in_valid(s1_v), .in_ready(s1_rdy), .in_data(s2_in),
    .out_valid(s2_v), .out_ready(s2_rdy), .out_data(s2_out)
  );
  if (SKID != 0) begin : g_skid
    sha2_pipe_stage #(.W(P2), .BYPASS(1'b1)) u_skid (
      .clk(clk), .rst(rst),
      .in_valid(s2_v), .in_ready(s2_rdy), .in_data(s2_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(res)
    );
  end else begin : g_direct
    assign out_valid = s2_v;
    assign s2_rdy    = out_ready;
    assign res       = s2_out;
  end
  assign t2 = res[WORD-1:0];
`ifdef SHA2_T2_NEW_A_EN
  assign new_a = res[2*WORD-1:WORD];
`endif
endmodule

// File: tb/tb_sha2_t2_pipe.sv
// tb_sha2_t2_pipe: directed and randomized-throttle checks of a 32-bit plain and a 64-bit skid instance
module tb_sha2_t2_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32, c32, t32;
  logic        iv64, ir64, ov64, or64;
  logic [63:0] a64, b64, c64, t64;
`ifdef SHA2_T2_NEW_A_EN
  logic [31:0] t1_32, na32;
  logic [63:0] t1_64, na64;
`endif
  int pass_n = 0, total_n = 0;
  logic [31:0] q32[$];
  logic [63:0] q64[$];
  int n_in32, n_out32, n_in64, n_out64;
  int first32, last32, nv32, first64, last64, nv64;

  sha2_t2_pipe #(.WORD(32), .SKID(0)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .c(c32),
`ifdef SHA2_T2_NEW_A_EN
    .t1(t1_32), .new_a(na32),
`endif
    .out_valid(ov32), .out_ready(or32), .t2(t32)
  );
  sha2_t2_pipe #(.WORD(64), .SKID(1)) u64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64), .c(c64),
`ifdef SHA2_T2_NEW_A_EN
    .t1(t1_64), .new_a(na64),
`endif
    .out_valid(ov64), .out_ready(or64), .t2(t64)
  );

  function automatic logic [31:0] m32(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    logic [31:0] s;
    s = {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    return s + ((x & y) | (x & z) | (y & z));
  endfunction
  function automatic logic [63:0] m64(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
    logic [63:0] s;
    s = {x[27:0], x[63:28]} ^ {x[33:0], x[63:34]} ^ {x[38:0], x[63:39]};
    return s + ((x & y) | (x & z) | (y & z));
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    assert (got === exp) pass_n++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run(input int n, input int low_pct);
    logic r;
    bit acc32, acc64, hold32, hold64;
    logic [31:0] h32;
    logic [63:0] h64;
    hold32 = 0; hold64 = 0;
    n_in32 = 0; n_out32 = 0; n_in64 = 0; n_out64 = 0;
    nv32 = 0; nv64 = 0; first32 = -1; first64 = -1; last32 = -1; last64 = -1;
    q32.delete(); q64.delete();
    or32 = 1; or64 = 1;
    a32 = $urandom; b32 = $urandom; c32 = $urandom;
    a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; c64 = {$urandom, $urandom};
    iv32 = 1; iv64 = 1;
    for (int cyc = 0; cyc < 20 * n + 50; cyc++) begin
      if (n_out32 >= n && n_out64 >= n) break;
      @(negedge clk);
      if (low_pct > 0) begin
        r = ir64;
        or64 = !or64;
        #1;
        chk("skid_in_ready_path", ir64, r);
        or64 = !or64;
        #1;
      end
      if (hold32) begin
        chk("t2_32_stable", t32, h32);
        chk("ov32_held", ov32, 1);
      end
      if (hold64) begin
        chk("t2_64_stable", t64, h64);
        chk("ov64_held", ov64, 1);
      end
      acc32 = iv32 && ir32;
      acc64 = iv64 && ir64;
      if (ov32) begin
        if (first32 < 0) first32 = cyc;
        last32 = cyc;
        nv32++;
      end
      if (ov64) begin
        if (first64 < 0) first64 = cyc;
        last64 = cyc;
        nv64++;
      end
      if (ov32 && or32) begin
        chk("t2_32_order", t32, (q32.size() > 0) ? 64'(q32.pop_front()) : 64'hX);
        n_out32++;
      end
      if (ov64 && or64) begin
        chk("t2_64_order", t64, (q64.size() > 0) ? q64.pop_front() : 64'hX);
        n_out64++;
      end
      hold32 = ov32 && !or32; h32 = t32;
      hold64 = ov64 && !or64; h64 = t64;
      @(posedge clk);
      #1;
      if (acc32) begin
        q32.push_back(m32(a32, b32, c32));
        n_in32++;
        a32 = $urandom; b32 = $urandom; c32 = $urandom;
      end
      if (acc64) begin
        q64.push_back(m64(a64, b64, c64));
        n_in64++;
        a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; c64 = {$urandom, $urandom};
      end
      iv32 = n_in32 < n;
      iv64 = n_in64 < n;
      or32 = $urandom_range(99) >= low_pct;
      or64 = $urandom_range(99) >= low_pct;
    end
    chk("n_out32", n_out32, n);
    chk("n_out64", n_out64, n);
    chk("q32_left", q32.size(), 0);
    chk("q64_left", q64.size(), 0);
    or32 = 1; or64 = 1; iv32 = 0; iv64 = 0;
  endtask

  initial begin
    rst = 1; iv32 = 0; iv64 = 0; or32 = 1; or64 = 1;
    a32 = 0; b32 = 0; c32 = 0; a64 = 0; b64 = 0; c64 = 0;
`ifdef SHA2_T2_NEW_A_EN
    t1_32 = 0; t1_64 = 0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ov32", ov32, 0); chk("rst_ir32", ir32, 1); chk("rst_t32", t32, 0);
    chk("rst_ov64", ov64, 0); chk("rst_ir64", ir64, 1); chk("rst_t64", t64, 0);
`ifdef SHA2_T2_NEW_A_EN
    chk("rst_na32", na32, 0); chk("rst_na64", na64, 0);
`endif
    a32 = 32'h6a09e667; b32 = 32'hbb67ae85; c32 = 32'h3c6ef372; iv32 = 1;
`ifdef SHA2_T2_NEW_A_EN
    t1_32 = 32'h54da50e8;
`endif
    chk("vec1_in_ready", ir32, 1);
    @(posedge clk); #1 iv32 = 0;
    @(negedge clk);
    chk("vec1_lat1_ov", ov32, 0);
    @(negedge clk);
    chk("vec1_lat2_ov", ov32, 1);
    chk("vec1_t2", t32, 32'h08909ae5);
`ifdef SHA2_T2_NEW_A_EN
    chk("vec1_new_a", na32, 32'h5d6aebcd);
    t1_32 = 0;
`endif
    @(posedge clk); #1;
    @(negedge clk);
    a32 = '1; b32 = '1; c32 = '1; a64 = '1; b64 = '1; c64 = '1; iv32 = 1; iv64 = 1;
    @(posedge clk); #1;
    a32 = 0; b32 = 0; c32 = 0; a64 = 0; b64 = 0; c64 = 0;
    @(posedge clk); #1;
    iv32 = 0; iv64 = 0;
    @(negedge clk);
    chk("ones_ov32", ov32, 1); chk("ones_t32", t32, 32'hFFFFFFFE);
    chk("ones_ov64", ov64, 1); chk("ones_t64", t64, 64'hFFFFFFFFFFFFFFFE);
    @(negedge clk);
    chk("zero_ov32", ov32, 1); chk("zero_t32", t32, 0);
    chk("zero_ov64", ov64, 1); chk("zero_t64", t64, 0);
    @(posedge clk); #1;
    run(8, 0);
    chk("b2b_span32", last32 - first32 + 1, 8); chk("b2b_cnt32", nv32, 8);
    chk("b2b_span64", last64 - first64 + 1, 8); chk("b2b_cnt64", nv64, 8);
    @(posedge clk); #1;
    run(40, 30);
    @(posedge clk); #1;
    a32 = 32'h11111111; b32 = 32'h22222222; c32 = 32'h33333333; iv32 = 1;
    a64 = 64'h0123456789abcdef; b64 = 64'hfedcba9876543210; c64 = 64'h0f0f0f0f0f0f0f0f; iv64 = 1;
    @(posedge clk); #1;
    a32 = 32'h44444444; a64 = 64'h5555555555555555;
    @(posedge clk); #1;
    rst = 1; iv32 = 0; iv64 = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_ov32", ov32, 0); chk("mid_rst_t32", t32, 0); chk("mid_rst_ir32", ir32, 1);
    chk("mid_rst_ov64", ov64, 0); chk("mid_rst_t64", t64, 0); chk("mid_rst_ir64", ir64, 1);
    a32 = 32'h6a09e667; b32 = 32'hbb67ae85; c32 = 32'h3c6ef372; iv32 = 1;
    a64 = '1; b64 = '1; c64 = '1; iv64 = 1;
    @(posedge clk); #1 iv32 = 0; iv64 = 0;
    @(negedge clk);
    chk("post_rst_lat1_ov32", ov32, 0); chk("post_rst_lat1_ov64", ov64, 0);
    @(negedge clk);
    chk("post_rst_ov32", ov32, 1); chk("post_rst_t32", t32, 32'h08909ae5);
    chk("post_rst_ov64", ov64, 1); chk("post_rst_t64", t64, 64'hFFFFFFFFFFFFFFFE);
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
